// File: rtl/wb_arbiter_pkg.sv
// Shared config for the write-back arbiter.
// Source slot numbering and default sizing.
package wb_arbiter_pkg;

  localparam int NUM_SRC_DEF      = 4;
  localparam int ROB_SIZE_BIT_CFG = 4;
  localparam int DATA_W_DEF       = 32;

  localparam int SRC_ALU = 0;
  localparam int SRC_LSB = 1;
  localparam int SRC_MUL = 2;
  localparam int SRC_AUX = 3;

endpackage

// File: rtl/wb_arbiter_rr_pick2.sv
// Round-robin pick of up to two requesters,
// scanning upward from ptr_i with wrap.
module rr_pick2 #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          g0_vld_o,
  output logic [PW-1:0] g0_idx_o,
  output logic          g1_vld_o,
  output logic [PW-1:0] g1_idx_o
);

  logic [PW-1:0] idx;

  always_comb begin
    g0_vld_o = 1'b0;
    g0_idx_o = '0;
    g1_vld_o = 1'b0;
    g1_idx_o = '0;
    idx      = ptr_i;
    for (int k = 0; k < N; k++) begin
      if (req_i[idx]) begin
        if (!g0_vld_o) begin
          g0_vld_o = 1'b1;
          g0_idx_o = idx;
        end else if (!g1_vld_o) begin
          g1_vld_o = 1'b1;
          g1_idx_o = idx;
        end
      end
      // explicit wrap keeps non-power-of-two N correct
      if (idx == PW'(N - 1)) idx = '0;
      else                   idx = idx + 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates NUM_SRC held results onto the
// ROB's two registered write-back ports.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC      = NUM_SRC_DEF,
  parameter int ROB_SIZE_BIT = ROB_SIZE_BIT_CFG,
  parameter int DATA_W       = DATA_W_DEF
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            rdy_in,
  input  logic                            clear,
  input  logic [NUM_SRC-1:0]              src_valid,
  input  logic [NUM_SRC*ROB_SIZE_BIT-1:0] src_rob_idx,
  input  logic [NUM_SRC*DATA_W-1:0]       src_value,
  output logic [NUM_SRC-1:0]              src_ready,
  output logic                            wb0_valid,
  output logic [ROB_SIZE_BIT-1:0]         wb0_rob_idx,
  output logic [DATA_W-1:0]               wb0_value,
  output logic                            wb1_valid,
  output logic [ROB_SIZE_BIT-1:0]         wb1_rob_idx,
  output logic [DATA_W-1:0]               wb1_value
);

  localparam int PW = $clog2(NUM_SRC);
  localparam int RW = ROB_SIZE_BIT;

  logic [NUM_SRC-1:0] hv_q, hv_d;
  logic [RW-1:0]      hidx_q [NUM_SRC];
  logic [RW-1:0]      hidx_d [NUM_SRC];
  logic [DATA_W-1:0]  hval_q [NUM_SRC];
  logic [DATA_W-1:0]  hval_d [NUM_SRC];
  logic [PW-1:0]      ptr_q, ptr_d;

  logic              wb0_v_q, wb0_v_d;
  logic [RW-1:0]     wb0_i_q, wb0_i_d;
  logic [DATA_W-1:0] wb0_x_q, wb0_x_d;
  logic              wb1_v_q, wb1_v_d;
  logic [RW-1:0]     wb1_i_q, wb1_i_d;
  logic [DATA_W-1:0] wb1_x_q, wb1_x_d;

  logic               g0_vld, g1_vld;
  logic [PW-1:0]      g0_idx, g1_idx;
  logic [NUM_SRC-1:0] grant;
  logic               open;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(NUM_SRC - 1)) ? '0 : p + 1'b1;
  endfunction

  rr_pick2 #(
    .N  (NUM_SRC),
    .PW (PW)
  ) u_pick (
    .req_i    (hv_q),
    .ptr_i    (ptr_q),
    .g0_vld_o (g0_vld),
    .g0_idx_o (g0_idx),
    .g1_vld_o (g1_vld),
    .g1_idx_o (g1_idx)
  );

  assign open = rdy_in && !clear && !rst_in;

  always_comb begin
    grant = '0;
    if (g0_vld) grant[g0_idx] = 1'b1;
    if (g1_vld) grant[g1_idx] = 1'b1;
    src_ready = {NUM_SRC{open}} & (~hv_q | grant);
  end

  always_comb begin
    hv_d    = hv_q;
    hidx_d  = hidx_q;
    hval_d  = hval_q;
    ptr_d   = ptr_q;
    wb0_v_d = wb0_v_q;
    wb0_i_d = wb0_i_q;
    wb0_x_d = wb0_x_q;
    wb1_v_d = wb1_v_q;
    wb1_i_d = wb1_i_q;
    wb1_x_d = wb1_x_q;
    if (clear) begin
      hv_d    = '0;
      ptr_d   = '0;
      wb0_v_d = 1'b0;
      wb1_v_d = 1'b0;
    end else begin
      wb0_v_d = g0_vld;
      wb1_v_d = g1_vld;
      if (g0_vld) begin
        wb0_i_d = hidx_q[g0_idx];
        wb0_x_d = hval_q[g0_idx];
      end
      if (g1_vld) begin
        wb1_i_d = hidx_q[g1_idx];
        wb1_x_d = hval_q[g1_idx];
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i] && src_ready[i]) begin
          hv_d[i]   = 1'b1;
          hidx_d[i] = src_rob_idx[i*RW +: RW];
          hval_d[i] = src_value[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          hv_d[i] = 1'b0;
        end
      end
      if (g1_vld)      ptr_d = nxt(g1_idx);
      else if (g0_vld) ptr_d = nxt(g0_idx);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hv_q    <= '0;
      ptr_q   <= '0;
      wb0_v_q <= 1'b0;
      wb0_i_q <= '0;
      wb0_x_q <= '0;
      wb1_v_q <= 1'b0;
      wb1_i_q <= '0;
      wb1_x_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        hidx_q[i] <= '0;
        hval_q[i] <= '0;
      end
    end else if (rdy_in) begin
      hv_q    <= hv_d;
      hidx_q  <= hidx_d;
      hval_q  <= hval_d;
      ptr_q   <= ptr_d;
      wb0_v_q <= wb0_v_d;
      wb0_i_q <= wb0_i_d;
      wb0_x_q <= wb0_x_d;
      wb1_v_q <= wb1_v_d;
      wb1_i_q <= wb1_i_d;
      wb1_x_q <= wb1_x_d;
    end
  end

  assign wb0_valid   = wb0_v_q;
  assign wb0_rob_idx = wb0_i_q;
  assign wb0_value   = wb0_x_q;
  assign wb1_valid   = wb1_v_q;
  assign wb1_rob_idx = wb1_i_q;
  assign wb1_value   = wb1_x_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised bench for wb_arbiter with a
// queue-level reference model and directed cases.
module tb_wb_arbiter;

  localparam int N  = 4;
  localparam int RW = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst, rdy, clr;
  logic [N-1:0]    sv;
  logic [N*RW-1:0] sidx;
  logic [N*DW-1:0] sval;
  logic [N-1:0]    srdy;
  logic            w0v, w1v;
  logic [RW-1:0]   w0i, w1i;
  logic [DW-1:0]   w0x, w1x;

  int pass_cnt = 0;
  int total    = 0;

  // reference model state
  bit          m_hv [N];
  int          m_hi [N];
  logic [31:0] m_hx [N];
  int          m_ptr;
  bit          m_w0v, m_w1v;
  int          m_w0i, m_w1i;
  logic [31:0] m_w0x, m_w1x;

  always #5 clk = ~clk;

  wb_arbiter #(
    .NUM_SRC      (N),
    .ROB_SIZE_BIT (RW),
    .DATA_W       (DW)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .rdy_in      (rdy),
    .clear       (clr),
    .src_valid   (sv),
    .src_rob_idx (sidx),
    .src_value   (sval),
    .src_ready   (srdy),
    .wb0_valid   (w0v),
    .wb0_rob_idx (w0i),
    .wb0_value   (w0x),
    .wb1_valid   (w1v),
    .wb1_rob_idx (w1i),
    .wb1_value   (w1x)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h",
                  nm, act, exp);
  endtask

  // first two held sources in circular order from m_ptr
  task automatic picks(output int g0, output int g1);
    g0 = -1;
    g1 = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (m_hv[j]) begin
        if (g0 < 0)      g0 = j;
        else if (g1 < 0) g1 = j;
      end
    end
  endtask

  function automatic logic [N-1:0] exp_rdy(int g0, int g1);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++)
      r[i] = !rst && rdy && !clr &&
             (!m_hv[i] || i == g0 || i == g1);
    return r;
  endfunction

  task automatic model_edge(input logic [N-1:0] acc,
                            input int g0,
                            input int g1);
    if (rst) begin
      for (int i = 0; i < N; i++) m_hv[i] = 0;
      m_ptr = 0;
      m_w0v = 0; m_w0i = 0; m_w0x = 0;
      m_w1v = 0; m_w1i = 0; m_w1x = 0;
    end else if (!rdy) begin
    end else if (clr) begin
      for (int i = 0; i < N; i++) m_hv[i] = 0;
      m_ptr = 0;
      m_w0v = 0;
      m_w1v = 0;
    end else begin
      m_w0v = (g0 >= 0);
      m_w1v = (g1 >= 0);
      if (g0 >= 0) begin
        m_w0i = m_hi[g0];
        m_w0x = m_hx[g0];
      end
      if (g1 >= 0) begin
        m_w1i = m_hi[g1];
        m_w1x = m_hx[g1];
      end
      for (int i = 0; i < N; i++) begin
        if (sv[i] && acc[i]) begin
          m_hv[i] = 1;
          m_hi[i] = int'(sidx[i*RW +: RW]);
          m_hx[i] = sval[i*DW +: DW];
        end else if (i == g0 || i == g1) begin
          m_hv[i] = 0;
        end
      end
      if (g1 >= 0)      m_ptr = (g1 + 1) % N;
      else if (g0 >= 0) m_ptr = (g0 + 1) % N;
    end
  endtask

  // called just after a posedge with inputs already driven
  task automatic tick();
    int g0, g1;
    logic [N-1:0] er;
    #2;
    picks(g0, g1);
    er = exp_rdy(g0, g1);
    chk("src_ready", 64'(srdy), 64'(er));
    @(posedge clk);
    model_edge(er, g0, g1);
    #1;
    chk("wb0_valid", 64'(w0v), 64'(m_w0v));
    chk("wb0_idx",   64'(w0i), 64'(m_w0i));
    chk("wb0_value", 64'(w0x), 64'(m_w0x));
    chk("wb1_valid", 64'(w1v), 64'(m_w1v));
    chk("wb1_idx",   64'(w1i), 64'(m_w1i));
    chk("wb1_value", 64'(w1x), 64'(m_w1x));
  endtask

  task automatic idle();
    sv = '0; sidx = '0; sval = '0;
  endtask

  task automatic put(input int s, input int idx,
                     input logic [31:0] v);
    sv[s] = 1'b1;
    sidx[s*RW +: RW] = RW'(idx);
    sval[s*DW +: DW] = v;
  endtask

  task automatic do_reset();
    rst = 1; rdy = 1; clr = 0;
    idle();
    tick();
    rst = 0;
  endtask

  int cnt [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      m_hv[i] = 0; m_hi[i] = 0; m_hx[i] = 0;
    end
    m_ptr = 0;
    m_w0v = 0; m_w0i = 0; m_w0x = 0;
    m_w1v = 0; m_w1i = 0; m_w1x = 0;
    rst = 1; rdy = 1; clr = 0;
    idle();
    tick();
    chk("reset_w0v", 64'(w0v), 64'd0);
    chk("reset_w0x", 64'(w0x), 64'd0);
    rst = 0;
    tick();

    // single source
    put(0, 3, 32'hDEADBEEF);
    tick();
    idle();
    #2;
    chk("single_rdy0", 64'(srdy[0]), 64'd1);
    tick();
    chk("single_w0v", 64'(w0v), 64'd1);
    chk("single_w0i", 64'(w0i), 64'd3);
    chk("single_w0x", 64'(w0x), 64'hDEADBEEF);
    chk("single_w1v", 64'(w1v), 64'd0);

    // three-way contention from rr_ptr 0
    do_reset();
    put(0, 5, 32'h55);
    put(1, 6, 32'h66);
    put(2, 7, 32'h77);
    tick();
    idle();
    tick();
    chk("three_w0i", 64'(w0i), 64'd5);
    chk("three_w1v", 64'(w1v), 64'd1);
    chk("three_w1i", 64'(w1i), 64'd6);
    tick();
    chk("three_w0v2", 64'(w0v), 64'd1);
    chk("three_w0i2", 64'(w0i), 64'd7);
    chk("three_w1v2", 64'(w1v), 64'd0);

    // fairness: all sources always valid
    do_reset();
    for (int i = 0; i < N; i++) put(i, i, 32'(i));
    for (int c = 0; c < 3; c++) tick();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (w0v) cnt[w0i % N]++;
      if (w1v) cnt[w1i % N]++;
    end
    for (int i = 0; i < N; i++)
      chk($sformatf("fair_src%0d", i), 64'(cnt[i]), 64'd4);

    // clear mid-operation
    do_reset();
    put(1, 1, 32'hA1);
    put(3, 3, 32'hA3);
    tick();
    idle();
    put(0, 10, 32'hA0);
    clr = 1;
    #2;
    chk("clear_rdy", 64'(srdy), 64'd0);
    tick();
    clr = 0;
    idle();
    chk("clear_w0v", 64'(w0v), 64'd0);
    chk("clear_w1v", 64'(w1v), 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("clear_after", 64'(w0v), 64'd0);
    end
    put(2, 2, 32'hB2);
    put(3, 4, 32'hB3);
    tick();
    idle();
    tick();
    chk("clear_ptr0", 64'(w0i), 64'd2);

    // stall with src2 held
    do_reset();
    put(2, 9, 32'h11);
    tick();
    idle();
    rdy = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall_rdy", 64'(srdy), 64'd0);
      chk("stall_w0v", 64'(w0v), 64'd0);
    end
    rdy = 1;
    tick();
    chk("stall_w0v1", 64'(w0v), 64'd1);
    chk("stall_w0i",  64'(w0i), 64'd9);
    chk("stall_w0x",  64'(w0x), 64'h11);

    // reset mid-traffic
    put(0, 12, 32'hC0);
    put(1, 13, 32'hC1);
    tick();
    tick();
    chk("mid_w0v_pre", 64'(w0v), 64'd1);
    rst = 1;
    #2;
    chk("mid_rdy", 64'(srdy), 64'd0);
    tick();
    rst = 0;
    idle();
    chk("mid_w0v", 64'(w0v), 64'd0);
    chk("mid_w0i", 64'(w0i), 64'd0);
    chk("mid_w1x", 64'(w1x), 64'd0);
    tick();
    chk("mid_empty", 64'(w0v), 64'd0);

    // randomised traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      rdy = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 24) == 0);
      for (int i = 0; i < N; i++) begin
        sv[i] = ($urandom_range(0, 9) < 6);
        sidx[i*RW +: RW] = RW'($urandom);
        sval[i*DW +: DW] = $urandom;
      end
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
